// File: rtl/display_arbiter.sv
// Round-robin owner of the seven-segment driver with a minimum dwell per owner.
// Ports: clk/rst, req/data per requester in; gnt/owner/busy/load/number out.
module display_arbiter #(
  parameter int N_REQ       = 4,
  parameter int HOLD_CYCLES = 200_000_000,
  parameter int CNT_W       = 28
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [32*N_REQ-1:0]  data,
  output logic [N_REQ-1:0]     gnt,
  output logic [2:0]           owner,
  output logic                 busy,
  output logic                 load,
  output logic [31:0]          number
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SHOW = 1'b1;

  localparam logic [2:0]       LAST_RST = 3'(N_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(HOLD_CYCLES - 1);

  logic [0:0]       state_q, state_d;
  logic [2:0]       owner_q, owner_d;
  logic [2:0]       last_q, last_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic             load_q, load_d;
  logic [31:0]      number_q, number_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [N_REQ-1:0] own_oh;
  logic [N_REQ-1:0] req_m;
  logic             own_req;
  logic [31:0]      own_data;
  logic             win_vld;
  logic [2:0]       win;
  logic [31:0]      win_data;

  // In SHOW the owner is masked out: on release its req is already low,
  // on expiry it must not win against itself.
  always_comb begin
    own_oh  = N_REQ'(1) << owner_q;
    own_req = |(req & own_oh);
    req_m   = req;
    if (state_q == S_SHOW) req_m = req & ~own_oh;
  end

  // Scan last+1, last+2, ... modulo N_REQ; first asserted bit wins.
  always_comb begin
    win_vld = 1'b0;
    win     = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!win_vld && req_m[i] &&
            ((int'(last_q) + k) % N_REQ) == i) begin
          win_vld = 1'b1;
          win     = 3'(i);
        end
      end
    end
  end

  always_comb begin
    own_data = '0;
    win_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (owner_q == 3'(i)) own_data = data[32*i +: 32];
      if (win == 3'(i))     win_data = data[32*i +: 32];
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    busy_d   = busy_q;
    load_d   = 1'b0;
    number_d = number_q;
    cnt_d    = cnt_q;
    if ((state_q == S_IDLE && win_vld) ||
        (state_q == S_SHOW && !own_req && win_vld) ||
        (state_q == S_SHOW && own_req &&
         cnt_q == CNT_END && win_vld)) begin
      state_d  = S_SHOW;
      owner_d  = win;
      last_d   = win;
      gnt_d    = N_REQ'(1) << win;
      busy_d   = 1'b1;
      load_d   = 1'b1;
      number_d = win_data;
      cnt_d    = '0;
    end else if (state_q == S_SHOW) begin
      if (!own_req) begin
        state_d = S_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end else if (cnt_q == CNT_END) begin
        // Nobody waiting: restart the dwell, keep the display.
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
        if (own_data != number_q) begin
          number_d = own_data;
          load_d   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      owner_q  <= '0;
      last_q   <= LAST_RST;
      gnt_q    <= '0;
      busy_q   <= 1'b0;
      load_q   <= 1'b0;
      number_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      busy_q   <= busy_d;
      load_q   <= load_d;
      number_q <= number_d;
      cnt_q    <= cnt_d;
    end
  end

  assign gnt    = gnt_q;
  assign owner  = owner_q;
  assign busy   = busy_q;
  assign load   = load_q;
  assign number = number_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Bench for display_arbiter: directed scenarios plus random traffic,
// every cycle compared against a timestamp-based reference model.
module tb_display_arbiter;

  localparam int N = 4;
  localparam int H = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req = '0;
  logic [127:0]  data = '0;
  logic [N-1:0]  gnt;
  logic [2:0]    owner;
  logic          busy;
  logic          load;
  logic [31:0]   number;

  always #5 clk = ~clk;

  display_arbiter #(
    .N_REQ      (N),
    .HOLD_CYCLES(H),
    .CNT_W      (4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .data  (data),
    .gnt   (gnt),
    .owner (owner),
    .busy  (busy),
    .load  (load),
    .number(number)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int loads  = 0;

  bit          m_show;
  int          m_owner;
  int          m_last;
  int          m_t;
  logic [31:0] m_number;
  bit          m_load;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic logic [31:0] lane(int i);
    return data[32*i +: 32];
  endfunction

  function automatic int pick(int skip);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (m_last + k) % N;
      if (req[i] && i != skip) return i;
    end
    return -1;
  endfunction

  task automatic grant(int w);
    m_owner  = w;
    m_last   = w;
    m_number = lane(w);
    m_load   = 1;
    m_show   = 1;
    m_t      = cyc;
  endtask

  // Dwell is tracked as the edge number at which the current dwell began.
  task automatic model_step();
    int w;
    m_load = 0;
    if (rst) begin
      m_show = 0; m_owner = 0; m_last = N - 1;
      m_number = 0; m_t = cyc;
    end else if (!m_show) begin
      w = pick(-1);
      if (w >= 0) grant(w);
    end else if (!req[m_owner]) begin
      w = pick(-1);
      if (w >= 0) grant(w);
      else m_show = 0;
    end else if (cyc - m_t == H) begin
      w = pick(m_owner);
      if (w >= 0) grant(w);
      else m_t = cyc;
    end else if (lane(m_owner) != m_number) begin
      m_number = lane(m_owner);
      m_load   = 1;
    end
  endtask

  task automatic cycle(bit r, logic [N-1:0] q, logic [127:0] d);
    @(negedge clk);
    rst  = r;
    req  = q;
    data = d;
    @(posedge clk);
    cyc++;
    model_step();
    #1;
    chk("gnt", 32'(gnt), m_show ? 32'(1 << m_owner) : 32'd0);
    chk("owner", 32'(owner), 32'(m_owner));
    chk("busy", 32'(busy), 32'(m_show));
    chk("load", 32'(load), 32'(m_load));
    chk("number", number, m_number);
    if (load) loads++;
  endtask

  initial begin
    logic [127:0] dv;
    logic [3:0]   rq;
    bit           rr;

    // reset with random inputs
    for (int i = 0; i < 2; i++)
      cycle(1'b1, 4'($urandom), {$urandom, $urandom, $urandom, $urandom});
    chk("rst_number", number, 32'd0);

    // single request
    dv = {$urandom, $urandom, $urandom, 32'hDEADBEEF};
    loads = 0;
    for (int i = 0; i < 22; i++) cycle(1'b0, 4'b0001, dv);
    chk("single_number", number, 32'hDEADBEEF);
    chk("single_loads", 32'(loads), 32'd1);

    // round robin 0,1,3,0,1
    cycle(1'b1, 4'b0000, dv);
    dv = {$urandom, $urandom, $urandom, $urandom};
    loads = 0;
    for (int i = 0; i < 33; i++) cycle(1'b0, 4'b1011, dv);
    chk("rr_loads", 32'(loads), 32'd5);
    chk("rr_owner", 32'(owner), 32'd1);

    // live update keeps the dwell running
    cycle(1'b1, 4'b0000, dv);
    dv[95:64] = 32'h00000001;
    for (int i = 1; i <= 3; i++) cycle(1'b0, 4'b0100, dv);
    dv[95:64] = 32'h12345678;
    cycle(1'b0, 4'b0100, dv);
    chk("live_load", 32'(load), 32'd1);
    chk("live_number", number, 32'h12345678);
    for (int i = 5; i <= 8; i++) cycle(1'b0, 4'b0101, dv);
    chk("live_hold", 32'(owner), 32'd2);
    cycle(1'b0, 4'b0101, dv);
    chk("live_handover", 32'(owner), 32'd0);

    // early release with wrap, then idle
    cycle(1'b1, 4'b0000, dv);
    cycle(1'b0, 4'b1000, dv);
    cycle(1'b0, 4'b1010, dv);
    cycle(1'b0, 4'b1010, dv);
    cycle(1'b0, 4'b0010, dv);
    chk("release_gnt", 32'(gnt), 32'h2);
    cycle(1'b0, 4'b0000, dv);
    chk("idle_gnt", 32'(gnt), 32'h0);
    chk("idle_number", number, dv[63:32]);

    // collision: expiry and data change on the same edge
    cycle(1'b1, 4'b0000, dv);
    for (int i = 1; i <= 8; i++) cycle(1'b0, 4'b0011, dv);
    dv[31:0] = ~dv[31:0];
    cycle(1'b0, 4'b0011, dv);
    chk("coll_owner", 32'(owner), 32'd1);
    chk("coll_number", number, dv[63:32]);
    cycle(1'b0, 4'b0011, dv);
    cycle(1'b1, 4'b0011, dv);
    chk("midshow_rst_busy", 32'(busy), 32'd0);
    chk("midshow_rst_num", number, 32'd0);

    // random traffic
    rq = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(5) == 0) rq = 4'($urandom);
      if ($urandom_range(3) == 0) begin
        int l;
        l = $urandom_range(3);
        dv[32*l +: 32] = $urandom_range(1) ? $urandom : 32'($urandom_range(3));
      end
      rr = ($urandom_range(199) == 0);
      cycle(rr, rq, dv);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
